// File: rtl/wb_retire_queue_if.sv
// Memory-stage to writeback-stage bus for wb_retire_queue.
//   master : mem stage (drives the instruction, samples ws_allowin)
//   slave  : writeback queue (samples the instruction, drives ws_allowin)
// Signals: ms_to_ws_valid, ws_allowin, ms_pc[31:0], ms_gr_we, ms_dest[4:0],
//          ms_result[DATA_W-1:0], ms_ex, ms_ertn
interface wb_retire_queue_if #(
    parameter int DATA_W = 32
);
    logic              ms_to_ws_valid;
    logic              ws_allowin;
    logic [31:0]       ms_pc;
    logic              ms_gr_we;
    logic [4:0]        ms_dest;
    logic [DATA_W-1:0] ms_result;
    logic              ms_ex;
    logic              ms_ertn;

    modport master (
        output ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_result, ms_ex, ms_ertn,
        input  ws_allowin
    );

    modport slave (
        input  ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_result, ms_ex, ms_ertn,
        output ws_allowin
    );
endinterface

// File: rtl/wb_retire_queue.sv
// Writeback/retire stage built as a DEPTH-entry in-order queue.
// Accepts completed instructions from the mem stage, retires at most one per
// cycle to the regfile write port (which may stall via rf_ready), raises
// exception/ertn flushes when the offending instruction reaches the head,
// drives the trace debug port and forwards pending writes to decode.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   ms_bus (slave)       : mem-stage valid/allowin handshake and instruction
//   rf_ready             : regfile write port available this cycle
//   rf_we/waddr/wdata    : regfile write
//   final_ex, ertn_flush : single-cycle flush pulses; flush_pc is their PC
//   ws_count             : queue occupancy
//   fwd_raddr/hit/data   : NUM_FWD forwarding lookup ports
//   debug_wb_*           : retire trace
module wb_retire_queue #(
    parameter int DEPTH   = 4,
    parameter int DATA_W  = 32,
    parameter int NUM_FWD = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    wb_retire_queue_if.slave             ms_bus,
    input  logic                         rf_ready,
    output logic                         rf_we,
    output logic [4:0]                   rf_waddr,
    output logic [DATA_W-1:0]            rf_wdata,
    output logic                         final_ex,
    output logic                         ertn_flush,
    output logic [31:0]                  flush_pc,
    output logic [$clog2(DEPTH+1)-1:0]   ws_count,
    input  logic [NUM_FWD*5-1:0]         fwd_raddr,
    output logic [NUM_FWD-1:0]           fwd_hit,
    output logic [NUM_FWD*DATA_W-1:0]    fwd_data,
    output logic [31:0]                  debug_wb_pc,
    output logic [3:0]                   debug_wb_rf_wen,
    output logic [4:0]                   debug_wb_rf_wnum,
    output logic [31:0]                  debug_wb_rf_wdata
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [31:0]       pc;
        logic              gr_we;
        logic [4:0]        dest;
        logic [DATA_W-1:0] result;
        logic              ex;
        logic              ertn;
    } entry_t;

    entry_t             q [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;

    entry_t             head_e;
    entry_t             ms_entry;
    logic               head_valid;
    logic               do_retire;
    logic               do_flush;
    logic               do_enq;

    assign head_e     = q[head];
    assign head_valid = (count != '0);

    assign ms_entry.pc     = ms_bus.ms_pc;
    assign ms_entry.gr_we  = ms_bus.ms_gr_we;
    assign ms_entry.dest   = ms_bus.ms_dest;
    assign ms_entry.result = ms_bus.ms_result;
    assign ms_entry.ex     = ms_bus.ms_ex;
    assign ms_entry.ertn   = ms_bus.ms_ertn;

    // Full blocks entry even if the head retires this cycle, so allowin never
    // depends on rf_ready.
    assign ms_bus.ws_allowin = (count != CNT_W'(DEPTH));

    // Only a writing, non-flushing head waits for the regfile port.
    assign do_retire = head_valid &&
                       (head_e.ex || head_e.ertn || !head_e.gr_we || rf_ready);
    assign do_flush  = do_retire && (head_e.ex || head_e.ertn);
    assign do_enq    = ms_bus.ms_to_ws_valid && ms_bus.ws_allowin && !do_flush;

    always_ff @(posedge clk) begin
        if (reset || do_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_enq)    tail <= tail + 1'b1;
            if (do_retire) head <= head + 1'b1;
            case ({do_enq, do_retire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset: entries are only observed below count.
    always_ff @(posedge clk) begin
        if (do_enq && !reset) q[tail] <= ms_entry;
    end

    always_comb begin
        rf_we      = do_retire && !do_flush;
        rf_waddr   = rf_we ? head_e.dest   : '0;
        rf_wdata   = rf_we ? head_e.result : '0;
        final_ex   = do_flush && head_e.ex;
        ertn_flush = do_flush && !head_e.ex;
        flush_pc   = do_flush ? head_e.pc : '0;
    end

    assign ws_count          = count;
    assign debug_wb_pc       = do_retire ? head_e.pc : '0;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = 32'(rf_wdata);

    // Walk oldest to youngest so the last match left standing is the youngest.
    // Offsets at or beyond count are stale slots and are skipped.
    logic [4:0]        lk_addr;
    logic              lk_hit;
    logic [DATA_W-1:0] lk_data;
    logic [PTR_W-1:0]  lk_idx;

    always_comb begin
        fwd_hit  = '0;
        fwd_data = '0;
        lk_addr  = '0;
        lk_hit   = 1'b0;
        lk_data  = '0;
        lk_idx   = '0;
        for (int unsigned p = 0; p < NUM_FWD; p++) begin
            lk_addr = fwd_raddr[p*5 +: 5];
            lk_hit  = 1'b0;
            lk_data = '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                lk_idx = head + PTR_W'(k);
                if ((CNT_W'(k) < count) && (lk_addr != 5'd0) &&
                    q[lk_idx].gr_we && !q[lk_idx].ex && (q[lk_idx].dest == lk_addr)) begin
                    lk_hit  = 1'b1;
                    lk_data = q[lk_idx].result;
                end
            end
            fwd_hit[p]                = lk_hit;
            fwd_data[p*DATA_W +: DATA_W] = lk_data;
        end
    end
endmodule

// File: doc/wb_retire_queue.md
# wb_retire_queue

Parametrised writeback/retire stage: accepts completed instructions from the memory stage through the standard valid/allowin handshake and holds them in a DEPTH-entry in-order queue. It retires at most one entry per cycle to the register-file write port, which may stall. It raises exception and ertn flushes when the offending instruction reaches the head, drives the trace debug interface, and forwards pending register writes to decode over NUM_FWD lookup ports. It sits between mem_stage and the regfile/CSR logic in place of a single-register writeback stage.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2
- DATA_W, 32: result width
- NUM_FWD, 2: forwarding lookup ports
- clk  in  1  clock; everything is on the rising edge
- reset  in  1  synchronous, active-high
- ms_to_ws_valid  in  1  mem stage has an instruction
- ws_allowin  out  1  queue can accept this cycle
- ms_pc  in  32  instruction PC
- ms_gr_we  in  1  instruction writes a GPR
- ms_dest  in  5  destination GPR
- ms_result  in  DATA_W  write data
- ms_ex  in  1  instruction carries an exception
- ms_ertn  in  1  instruction is ertn
- rf_ready  in  1  regfile write port available this cycle
- rf_we / rf_waddr / rf_wdata  out  1/5/DATA_W  regfile write
- final_ex  out  1  exception flush pulse
- ertn_flush  out  1  ertn flush pulse
- flush_pc  out  32  PC of the flushing instruction
- ws_count  out  $clog2(DEPTH+1)  occupancy
- fwd_raddr  in  NUM_FWD*5  lookup register numbers
- fwd_hit  out  NUM_FWD  pending write found
- fwd_data  out  NUM_FWD*DATA_W  youngest pending data
- debug_wb_pc / debug_wb_rf_wen / debug_wb_rf_wnum / debug_wb_rf_wdata  out  32/4/5/32  trace

## Operation
- Entry fields: pc, gr_we, dest, result, ex, ertn. Head/tail pointers are log2(DEPTH) bits, wrap modulo DEPTH; count is tracked separately so full and empty are unambiguous.
- ws_allowin = (count != DEPTH). A full queue does not accept an entry even when the head retires in the same cycle.
- Enqueue when ms_to_ws_valid && ws_allowin and no flush this cycle.
- Head retire condition (head valid):
  - head.ex or head.ertn: retire unconditionally.
  - !head.gr_we: retire unconditionally.
  - otherwise: retire only when rf_ready.
- Normal retire: rf_we=1, rf_waddr=head.dest, rf_wdata=head.result. A retire to dest 0 still drives rf_we; the regfile ignores r0.
- Exception retire (ex has priority over ertn): rf_we=0; final_ex=1 if ex, else ertn_flush=1; flush_pc=head.pc. On the next edge the queue clears (count=0, pointers=0). A same-cycle enqueue is dropped.
- Forwarding, per port i: scan valid entries for gr_we && !ex && dest==fwd_raddr[i]. fwd_hit=1 and fwd_data=result of the youngest match. fwd_raddr==0 always gives hit=0, data=0. The head entry being retired this cycle still counts as a hit. Incoming ms_* data is not searched. Purely combinational.
- Debug: debug_wb_pc=head.pc whenever an entry retires, else 0. debug_wb_rf_wen={4{rf_we}}. wnum/wdata follow rf_waddr/rf_wdata.

## Timing
- Reset: queue empty, count=0, ws_allowin=1. rf_we, final_ex, ertn_flush, fwd_hit, and all debug outputs are 0. flush_pc and rf_wdata are 0.
- Minimum latency from enqueue edge to retire: 1 cycle. An entry enqueued at edge N can retire in cycle N+1; no bypass from empty.
- Throughput: 1 retire/cycle. Enqueue and retire can occur in the same cycle; count is then unchanged.
- Flush outputs are single-cycle pulses, combinational from head state. The queue is empty on the cycle after the pulse.
- rf_ready low stalls only a writing head. The queue fills; ws_allowin drops the same cycle count reaches DEPTH.
- Reset asserted mid-operation discards all entries regardless of rf_ready or pending flush.

## Test plan
- Streaming: 8 back-to-back writes (dest 1..8, result 0x100+dest), rf_ready=1 -> rf_we every cycle after the first; ws_count stays ≤1; trace order matches PCs.
- Backpressure: rf_ready=0, issue 5 writes with DEPTH=4 -> ws_allowin=0 after 4 accepted, 5th held. Raise rf_ready -> 5 retirements in order, no loss or duplicate.
- Exception: queue {add r3, ex(pc 0x1c008010), add r4}, plus an enqueue in the flush cycle -> r3 written; final_ex=1 for one cycle with flush_pc=0x1c008010; r4 and the new entry are never written; count=0 next cycle.
- Ertn: an ertn at the head -> ertn_flush=1 for one cycle, final_ex=0, rf_we=0, queue cleared.
- Forwarding: entries r5=0xAA then r5=0xBB pending, rf_ready=0 -> fwd port r5 returns hit=1, data=0xBB. Port r0 returns hit=0. An ex entry with dest r6 -> hit=0.
- Reset mid-stall: queue full, reset for one cycle -> count=0, ws_allowin=1, all outputs 0.
